serial_rx: RTL and testbench
============================

Name: serial_rx

Overview:
- 8N1 UART receiver, LSB first.
- Companion to the team's serial transmitter: same bit-period parameterisation, so a TX/RX pair built with equal `delay` interoperates.
- Oversamples the asynchronous `serialIn` line with the system clock and samples each bit at mid-period.
- Presents each received byte with a valid pulse, a sticky "available" flag with a read handshake, and overrun and framing error reporting.

Parameters:
- counterBits, 8, width of bit-period counter; must hold `delay`.
- delay, 234, clocks per bit (27 MHz / 115200).
- halfDelay, delay/2 (117), clocks from detected start edge to start-bit mid-sample.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- resetN  input  1  synchronous active-low reset.
- serialIn  input  1  asynchronous serial line, idle high.
- data  output  8  last correctly framed byte.
- dataValid  output  1  one-clock pulse when `data` updates.
- dataAvailable  output  1  sticky: unread byte present.
- dataRead  input  1  consumer strobe; clears `dataAvailable` and `overrun`.
- overrun  output  1  sticky: byte completed while `dataAvailable` was already 1.
- frameError  output  1  one-clock pulse: stop bit sampled low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (resetN=0 at clk edge):
  - state=IDLE; data=0x00; dataValid=0; dataAvailable=0; overrun=0; frameError=0.
  - Both synchroniser flops=1; counter=0.
  - Reset mid-frame abandons the frame; no pulses are generated.
- Synchroniser: 2 flops, giving `rxSync`. A third flop `rxPrev` holds the previous `rxSync` for edge detection. All decisions use `rxSync` only.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: when rxPrev=1 and rxSync=0 → START, counter←1.
- START: counter increments each clock. When counter==halfDelay:
  - rxSync=0 → DATA, counter←1, bitCount←0.
  - rxSync=1 → IDLE (glitch rejected; no outputs change).
- DATA: when counter==delay:
  - shift ← {rxSync, shift[7:1]}, counter←1, bitCount←bitCount+1.
  - After the 8th sample (bitCount==7) → STOP.
  - Otherwise counter increments.
- STOP: when counter==delay, sample rxSync:
  - rxSync=1: data←shift; dataValid=1 for one clock; dataAvailable←1. If dataAvailable was already 1 and dataRead is not asserted that cycle, overrun←1. → IDLE.
  - rxSync=0: frameError=1 for one clock; data, dataAvailable and overrun are unchanged. → BREAK.
- BREAK: stay until rxSync=1, then → IDLE. A held-low line (break) produces exactly one frameError.
- Return to IDLE happens at mid-stop-bit, so a back-to-back start bit from the transmitter is caught.
- Timing: the stop sample occurs halfDelay + 9·delay clocks after the detection edge. dataValid is visible on the following cycle.
- dataRead:
  - Level-sampled each clock; when 1, clears dataAvailable and overrun.
  - If a byte completes on the same clock, the new byte wins: dataAvailable=1, overrun is not set (the old byte counts as consumed).
  - dataRead while dataAvailable=0 has no effect.
- Counter compares are exact equality. counterBits must cover delay; the counter never wraps in legal use.
- busy=0 only in IDLE; it does not depend on dataAvailable.

Test Plan:
- delay=16, halfDelay=8. Drive 0xA5 (start, 1,0,1,0,0,1,0,1, stop), bit period 16 clk → one dataValid pulse 152 clk after the start-detection edge; data=0xA5; dataAvailable=1; frameError=0.
- Loopback with the team's transmitter (same delay): send 0x00, 0xFF, 0x5A back-to-back with no idle gap → three dataValid pulses; data sequence 0x00, 0xFF, 0x5A; no frameError.
- Glitch: serialIn low for 4 clk, then high → no dataValid; busy returns to 0 by 8 clk after detection; state is IDLE.
- Stop bit forced low on byte 0x3C, line then held low 50 clk → one frameError pulse; data unchanged from prior value; busy=1 until line high; next valid frame 0x81 is received correctly.
- Overrun: receive 0x11 without dataRead, then 0x22 → data=0x22, overrun=1. Pulse dataRead → dataAvailable=0, overrun=0. dataRead coinciding with the completion cycle of a third byte → dataAvailable=1, overrun=0.
- Assert resetN=0 for 1 clk during bit 4 of a frame → all outputs at reset values; the remaining bits of that frame produce no dataValid; the next full frame 0xC3 is received correctly.

Source files
------------

// File: rtl/serial_rx.sv
// 8N1 UART receiver, LSB first: two-flop synchroniser, mid-bit sampling,
// sticky available/overrun flags with a read strobe, and framing-error pulse.
module serial_rx #(
  parameter int counterBits = 8,
  parameter int delay       = 234,
  parameter int halfDelay   = delay / 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       serialIn,
  output logic [7:0] data,
  output logic       dataValid,
  output logic       dataAvailable,
  input  logic       dataRead,
  output logic       overrun,
  output logic       frameError,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [counterBits-1:0] DELAY_C = counterBits'(delay);
  localparam logic [counterBits-1:0] HALF_C  = counterBits'(halfDelay);
  localparam logic [counterBits-1:0] ONE_C   = counterBits'(1);

  state_t                 state;
  logic                   rx_meta;
  logic                   rx_sync;
  logic                   rx_prev;
  logic [counterBits-1:0] counter;
  logic [2:0]             bit_count;
  logic [7:0]             shift_reg;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      // NOTE: every flop, the shift register included, is reset so a frame cut
      // short by reset leaves no trace; the synchroniser resets to the idle level.
      state         <= S_IDLE;
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_prev       <= 1'b1;
      counter       <= '0;
      bit_count     <= '0;
      shift_reg     <= '0;
      data          <= '0;
      dataValid     <= 1'b0;
      dataAvailable <= 1'b0;
      overrun       <= 1'b0;
      frameError    <= 1'b0;
    end else begin
      rx_meta <= serialIn;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;

      // NOTE: non-blocking assignments later in this block override earlier
      // ones, so pulses default low here and a completing byte beats the read clear.
      dataValid  <= 1'b0;
      frameError <= 1'b0;
      if (dataRead) begin
        dataAvailable <= 1'b0;
        overrun       <= 1'b0;
      end

      unique case (state)
        S_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state   <= S_START;
            counter <= ONE_C;
          end
        end

        S_START: begin
          if (counter == HALF_C) begin
            if (!rx_sync) begin
              state     <= S_DATA;
              counter   <= ONE_C;
              bit_count <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            counter <= counter + ONE_C;
          end
        end

        S_DATA: begin
          if (counter == DELAY_C) begin
            shift_reg <= {rx_sync, shift_reg[7:1]};
            counter   <= ONE_C;
            bit_count <= bit_count + 3'd1;
            if (bit_count == 3'd7) state <= S_STOP;
          end else begin
            counter <= counter + ONE_C;
          end
        end

        S_STOP: begin
          // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
          if (counter == DELAY_C) begin
            if (rx_sync) begin
              data          <= shift_reg;
              dataValid     <= 1'b1;
              dataAvailable <= 1'b1;
              overrun       <= !dataRead && (overrun || dataAvailable);
              state         <= S_IDLE;
            end else begin
              frameError <= 1'b1;
              state      <= S_BREAK;
            end
          end else begin
            counter <= counter + ONE_C;
          end
        end

        S_BREAK: begin
          if (rx_sync) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx at 16 clocks per bit: table of framed bytes
// followed by glitch, framing-error/break and mid-frame reset sequences.
module tb_serial_rx;

  localparam int BIT = 16;

  logic       clk;
  logic       resetN;
  logic       serialIn;
  logic [7:0] data;
  logic       dataValid;
  logic       dataAvailable;
  logic       dataRead;
  logic       overrun;
  logic       frameError;
  logic       busy;

  serial_rx #(
    .counterBits(8),
    .delay      (BIT),
    .halfDelay  (BIT / 2)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .serialIn     (serialIn),
    .data         (data),
    .dataValid    (dataValid),
    .dataAvailable(dataAvailable),
    .dataRead     (dataRead),
    .overrun      (overrun),
    .frameError   (frameError),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_count = 0;
  int check_count = 0;

  int cycle = 0;
  int valid_count = 0;
  int valid_cycle = 0;
  int ferr_count = 0;
  int busy_rise = 0;
  int busy_cycles = 0;
  logic busy_q = 1'b0;

  // Samples DUT outputs 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cycle++;
    if (dataValid === 1'b1) begin
      valid_count++;
      valid_cycle = cycle;
    end
    if (frameError === 1'b1) ferr_count++;
    if (busy === 1'b1 && busy_q !== 1'b1) busy_rise = cycle;
    if (busy === 1'b1) busy_cycles++;
    busy_q = busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic send_frame(input logic [7:0] value, input logic stop);
    logic [9:0] f;
    f = {stop, value, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serialIn = f[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic pulse_read();
    @(negedge clk);
    dataRead = 1'b1;
    @(negedge clk);
    dataRead = 1'b0;
  endtask

  typedef struct {
    logic [7:0] value;
    int         gap;
    bit         read_before;
    bit         read_coincident;
    logic [7:0] exp_data;
    bit         exp_avail;
    bit         exp_ovr;
    int         exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int v0;
    int f0;
    int b0;

    // value, idle gap, read before, read on completion, data, avail, overrun, latency
    vecs[0] = '{8'hA5, 4, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 152};
    vecs[1] = '{8'h00, 4, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0};
    vecs[2] = '{8'hFF, 0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 0};
    vecs[3] = '{8'h5A, 0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b1, 0};
    vecs[4] = '{8'h11, 4, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 0};
    vecs[5] = '{8'h22, 4, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 0};
    vecs[6] = '{8'h33, 4, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 0};
    vecs[7] = '{8'h44, 4, 1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 0};

    resetN   = 1'b0;
    serialIn = 1'b1;
    dataRead = 1'b0;
    repeat (3) @(negedge clk);
    check("reset data", 32'(data), 32'h00);
    check("reset dataValid", 32'(dataValid), 32'd0);
    check("reset dataAvailable", 32'(dataAvailable), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    check("reset frameError", 32'(frameError), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    resetN = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      repeat (vecs[i].gap) @(negedge clk);
      if (vecs[i].read_before) begin
        pulse_read();
        check($sformatf("v%0d read clears avail", i), 32'(dataAvailable), 32'd0);
        check($sformatf("v%0d read clears overrun", i), 32'(overrun), 32'd0);
      end
      v0 = valid_count;
      f0 = ferr_count;
      if (vecs[i].read_coincident) begin
        fork
          send_frame(vecs[i].value, 1'b1);
          begin
            // Stop sample lands on the 155th rising edge after the start bit is driven.
            repeat (154) @(negedge clk);
            dataRead = 1'b1;
            @(negedge clk);
            dataRead = 1'b0;
          end
        join
      end else begin
        send_frame(vecs[i].value, 1'b1);
      end
      check($sformatf("v%0d valid pulses", i), 32'(valid_count - v0), 32'd1);
      check($sformatf("v%0d data", i), 32'(data), 32'(vecs[i].exp_data));
      check($sformatf("v%0d dataAvailable", i), 32'(dataAvailable), 32'(vecs[i].exp_avail));
      check($sformatf("v%0d overrun", i), 32'(overrun), 32'(vecs[i].exp_ovr));
      check($sformatf("v%0d no frameError", i), 32'(ferr_count - f0), 32'd0);
      if (vecs[i].exp_lat != 0)
        check($sformatf("v%0d detect-to-valid", i), 32'(valid_cycle - busy_rise), 32'(vecs[i].exp_lat));
    end

    // Glitch: 4 clocks low is rejected at the half-bit sample.
    repeat (4) @(negedge clk);
    v0 = valid_count;
    b0 = busy_cycles;
    serialIn = 1'b0;
    repeat (4) @(negedge clk);
    serialIn = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch busy cycles", 32'(busy_cycles - b0), 32'd8);
    check("glitch busy idle", 32'(busy), 32'd0);
    check("glitch no valid", 32'(valid_count - v0), 32'd0);

    // Framing error followed by a held-low line, then recovery.
    v0 = valid_count;
    f0 = ferr_count;
    send_frame(8'h3C, 1'b0);
    repeat (50) @(negedge clk);
    check("break busy", 32'(busy), 32'd1);
    check("break one frameError", 32'(ferr_count - f0), 32'd1);
    check("break no valid", 32'(valid_count - v0), 32'd0);
    check("break data kept", 32'(data), 32'h44);
    check("break avail kept", 32'(dataAvailable), 32'd1);
    serialIn = 1'b1;
    repeat (6) @(negedge clk);
    check("break released busy", 32'(busy), 32'd0);
    check("break still one frameError", 32'(ferr_count - f0), 32'd1);
    pulse_read();
    send_frame(8'h81, 1'b1);
    check("after break valid", 32'(valid_count - v0), 32'd1);
    check("after break data", 32'(data), 32'h81);
    check("after break overrun", 32'(overrun), 32'd0);

    // Reset during bit 4 of a 0xF0 frame; the line stays high afterwards.
    repeat (4) @(negedge clk);
    v0 = valid_count;
    serialIn = 1'b0;
    repeat (5 * BIT) @(negedge clk);
    serialIn = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    check("midreset data", 32'(data), 32'h00);
    check("midreset dataValid", 32'(dataValid), 32'd0);
    check("midreset dataAvailable", 32'(dataAvailable), 32'd0);
    check("midreset overrun", 32'(overrun), 32'd0);
    check("midreset frameError", 32'(frameError), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    repeat (6 * BIT) @(negedge clk);
    check("midreset no valid", 32'(valid_count - v0), 32'd0);
    send_frame(8'hC3, 1'b1);
    check("post reset valid", 32'(valid_count - v0), 32'd1);
    check("post reset data", 32'(data), 32'hC3);
    check("post reset avail", 32'(dataAvailable), 32'd1);
    check("post reset overrun", 32'(overrun), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
